soc_ahb_apb_bridge: RTL and testbench
=====================================

# soc_ahb_apb_bridge

AHB-Lite responder and APB initiator for the peripheral subsystem. It accepts single AHB-Lite transfers from the Cortex-M0 bus, selected by the AHB decoder, and converts each one into a two-phase APB transfer (SETUP then ACCESS) towards APB slaves such as the ADC wrapper. AHB wait states are inserted until the APB slave completes, and APB errors are returned as the AHB two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 12, APB address width; paddr is taken from haddr[ADDR_WIDTH-1:0].
- DATA_WIDTH, 32, data width on both buses.

- fclk  in  1  clock; AHB and APB share it.
- resetn  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select from the AHB decoder.
- haddr  in  32  AHB address.
- htrans  in  2  transfer type; bit 1 set means NONSEQ or SEQ.
- hsize  in  3  transfer size.
- hwrite  in  1  1 = write.
- hready  in  1  bus HREADY from the AHB mux.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hreadyout  out  1  this slave's ready.
- hrdata  out  DATA_WIDTH  read data.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- paddr  out  ADDR_WIDTH  APB address; bits [1:0] are always 0.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

## Operation
- All outputs are registered.
- Reset values:
  - hreadyout = 1, hresp = 0, hrdata = 0.
  - psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0.
- Accept condition: hsel & hready & htrans[1], sampled on a rising fclk edge.
- Transfers with htrans of IDLE or BUSY complete with OKAY and zero wait states. No APB activity results.
- On accept, the bridge latches haddr[ADDR_WIDTH-1:2] (with [1:0] forced to 0) and hwrite.
- Supported size is word only (hsize = 3'b010). Any other size is rejected: two-cycle ERROR response, and no APB transfer is issued.
- States:
  - IDLE: hreadyout = 1, no APB activity.
    - Accepted read goes to SETUP.
    - Accepted write goes to WDATA.
    - Accepted non-word transfer goes to ERR1.
  - WDATA: hreadyout = 0. hwdata is sampled into pwdata at the end of this cycle. Next state is SETUP.
  - SETUP: psel = 1, penable = 0, hreadyout = 0. Next state is ACCESS.
  - ACCESS: psel = 1, penable = 1, hreadyout = 0.
    - While pready = 0: stay in ACCESS, with paddr, pwrite and pwdata held stable.
    - pready = 1 and pslverr = 0: next state is IDLE with hreadyout = 1. For reads, hrdata is loaded with prdata.
    - pready = 1 and pslverr = 1: next state is ERR1. hrdata is not updated.
  - ERR1: hresp = 1, hreadyout = 0, psel = 0, penable = 0. Next state is ERR2.
  - ERR2: hresp = 1, hreadyout = 1. A transfer may be accepted here under the normal accept rule.
- hrdata holds its last loaded value until the next successful read.
- A new transfer may be accepted in the IDLE/completion cycle or in ERR2, which gives back-to-back operation.
- Address phases presented while hreadyout = 0 are never accepted; the bridge relies on hready being low during that time.
- pslverr is ignored unless pready = 1 in ACCESS.
- No timeout: a slave that never asserts pready stalls the bus indefinitely.
- Reset asserted mid-transfer immediately forces all outputs to their reset values, including dropping psel/penable. The transfer is abandoned.

## Timing
- Cycle 0 is the accepting edge.
- Read with pready = 1 on first ACCESS:
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS.
  - Cycle 3: hreadyout = 1 and hrdata valid.
  - Total: 2 AHB wait states.
- Write with pready = 1 on first ACCESS:
  - Cycle 1: WDATA.
  - Cycle 2: SETUP, pwdata valid.
  - Cycle 3: ACCESS.
  - Cycle 4: hreadyout = 1.
  - Total: 3 wait states.
- Each cycle of pready = 0 in ACCESS adds one wait state.
- APB error: ERR1 follows the completing ACCESS cycle, then ERR2. The error adds 1 cycle compared with OKAY completion.
- Non-word rejection: ERR1 at cycle 1, ERR2 at cycle 2.
- psel and penable fall in the cycle after the completing ACCESS.

## Test plan
- Reset then idle: all outputs at their reset values. htrans = IDLE with hsel = 1 gives hreadyout = 1, hresp = 0 and psel never asserted.
- Word write to haddr 0x4000_0A14 with hwdata 0xDEADBEEF, pready tied 1:
  - paddr = 0xA14, pwrite = 1, pwdata = 0xDEADBEEF.
  - psel rises cycle 2, penable high cycle 3 only, hreadyout high cycle 4.
- Word read with pready low for 3 ACCESS cycles, prdata = 0x1234_5678:
  - APB outputs stable through the stall.
  - hreadyout returns at cycle 6 with hrdata = 0x12345678.
- Read with pslverr = 1:
  - ERR1 gives hresp = 1, hreadyout = 0; ERR2 gives hresp = 1, hreadyout = 1.
  - hrdata keeps its previous value.
  - A read accepted in ERR2 completes normally.
- Byte write (hsize = 0): psel never asserts, ERR1/ERR2 at cycles 1/2. Then back-to-back read, write, read with no idle cycles all complete correctly.
- Assert resetn low during ACCESS: psel, penable and hreadyout reach their reset values with no fclk edge, and the next transfer after release works.

Source files
------------

// File: rtl/soc_ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// soc_ahb_apb_bridge
//   AHB-Lite responder / APB initiator. Each accepted word transfer becomes one
//   APB SETUP+ACCESS pair; AHB wait states are held until the APB slave
//   answers, and an APB error (or a non-word AHB size) is returned as the
//   two-cycle AHB ERROR response. All outputs are registered.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | hreadyout=1, no APB activity, may accept a transfer
//   WDATA  | write data phase, hwdata captured into pwdata at cycle end
//   SETUP  | APB setup: psel=1, penable=0
//   ACCESS | APB access: psel=1, penable=1, wait for pready
//   ERR1   | first ERROR cycle: hresp=1, hreadyout=0
//   ERR2   | second ERROR cycle: hresp=1, hreadyout=1, may accept
//
// Ports
//   fclk, resetn            clock, async active-low reset
//   hsel, haddr, htrans,
//   hsize, hwrite, hready,
//   hwdata                  AHB-Lite responder inputs
//   hreadyout, hrdata, hresp AHB-Lite responder outputs
//   paddr, psel, penable,
//   pwrite, pwdata          APB initiator outputs
//   prdata, pready, pslverr APB initiator inputs
// -----------------------------------------------------------------------------
module soc_ahb_apb_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  fclk,
    input  logic                  resetn,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic                  hwrite,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hreadyout,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hresp,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t state;
    logic   accept;
    logic   size_word;
    logic   unused_bits;

    assign accept    = hsel & hready & htrans[1];
    assign size_word = (hsize == 3'b010);

    // Upper address bits, byte offset and the SEQ/NONSEQ distinction play no
    // part in the conversion.
    assign unused_bits = ^{haddr[31:ADDR_WIDTH], haddr[1:0], htrans[0]};

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            case (state)
                // ERR2 ends the error response exactly like IDLE ends an OKAY
                // one, so both share the accept logic.
                S_IDLE, S_ERR2: begin
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    if (accept) begin
                        paddr     <= {haddr[ADDR_WIDTH-1:2], 2'b00};
                        pwrite    <= hwrite;
                        hreadyout <= 1'b0;
                        if (!size_word) begin
                            state <= S_ERR1;
                            hresp <= 1'b1;
                        end else if (hwrite) begin
                            state <= S_WDATA;
                        end else begin
                            state <= S_SETUP;
                            psel  <= 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    pwdata <= hwdata;
                    psel   <= 1'b1;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            hresp <= 1'b1;
                            state <= S_ERR1;
                        end else begin
                            hreadyout <= 1'b1;
                            state     <= S_IDLE;
                            if (!pwrite) begin
                                hrdata <= prdata;
                            end
                        end
                    end
                end
                S_ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= S_ERR2;
                end
                default: begin
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_soc_ahb_apb_bridge
//   Directed stimulus for soc_ahb_apb_bridge. The driver pushes the expected
//   AHB response and expected APB transfer for every accepted transfer; an AHB
//   monitor and an APB slave/monitor pop and compare independently.
//   Cycle numbers count from the accepting edge (cycle 0).
// -----------------------------------------------------------------------------
module tb_soc_ahb_apb_bridge;

    logic        fclk;
    logic        resetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    // Single slave on the bus: the AHB mux returns our own ready.
    assign hready = hreadyout;

    soc_ahb_apb_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .fclk(fclk), .resetn(resetn), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hready(hready),
        .hwdata(hwdata), .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        int          acc;
        bit          rd;
        bit          resp;
        int          lat;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        int          acc;
        int          setup;
        logic [11:0] addr;
        bit          wr;
        logic [31:0] wdata;
        int          stall;
        bit          err;
        logic [31:0] rdata;
    } apb_t;

    sb_t  sb_q[$];
    apb_t apb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   acnt   = 0;

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    always @(posedge fclk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // AHB response monitor
    always @(negedge fclk) begin
        if (resetn && sb_q.size() > 0) begin
            sb_t s;
            s = sb_q[0];
            if (hreadyout) begin
                void'(sb_q.pop_front());
                chk("ahb_hresp", {31'd0, hresp}, {31'd0, s.resp});
                chk("ahb_done_cycle", cyc - s.acc + 1, s.lat);
                if (s.rd) chk("ahb_hrdata", hrdata, s.rdata);
            end else if (hresp) begin
                chk("err1_resp", {31'd0, s.resp}, 32'd1);
                chk("err1_cycle", cyc - s.acc + 1, s.lat - 1);
            end
        end
    end

    // APB slave model and APB monitor (one block so response and check agree)
    always @(negedge fclk) begin
        if (!resetn) begin
            pready  = 1'b0;
            pslverr = 1'b0;
            acnt    = 0;
        end else if (psel) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected_psel", {31'd0, psel}, 32'd0);
            end else begin
                apb_t a;
                a = apb_q[0];
                chk("apb_paddr", {20'd0, paddr}, {20'd0, a.addr});
                chk("apb_pwrite", {31'd0, pwrite}, {31'd0, a.wr});
                if (a.wr) chk("apb_pwdata", pwdata, a.wdata);
                if (!penable) begin
                    chk("apb_setup_cycle", cyc - a.acc + 1, a.setup);
                    acnt    = 0;
                    pready  = 1'b0;
                    pslverr = 1'b0;
                end else begin
                    pready  = (acnt == a.stall);
                    pslverr = pready & a.err;
                    prdata  = a.rdata;
                    acnt++;
                    if (pready) void'(apb_q.pop_front());
                end
            end
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                         input logic [31:0] wd, input bit do_apb, input int setup,
                         input int stall, input bit err, input logic [31:0] rd,
                         input bit exp_resp, input int lat, input logic [31:0] exp_rd);
        int n = 0;
        sb_t  s;
        apb_t a;
        hsel   = 1'b1;
        haddr  = addr;
        htrans = 2'b10;
        hsize  = size;
        hwrite = wr;
        while (!hreadyout && n < 200) begin
            @(negedge fclk);
            n++;
        end
        if (!hreadyout) begin
            chk("accept_timeout", 32'd0, 32'd1);
            htrans = 2'b00;
            return;
        end
        @(posedge fclk);
        #1;
        s.acc = cyc; s.rd = !wr; s.resp = exp_resp; s.lat = lat; s.rdata = exp_rd;
        sb_q.push_back(s);
        if (do_apb) begin
            a.acc = cyc; a.setup = setup; a.addr = {addr[11:2], 2'b00}; a.wr = wr;
            a.wdata = wd; a.stall = stall; a.err = err; a.rdata = rd;
            apb_q.push_back(a);
        end
        @(negedge fclk);
        htrans = 2'b00;
        if (wr) hwdata = wd;
    endtask

    task automatic drain();
        int n = 0;
        htrans = 2'b00;
        while ((sb_q.size() != 0 || apb_q.size() != 0) && n < 300) begin
            @(negedge fclk);
            n++;
        end
        chk("drain_pending", sb_q.size() + apb_q.size(), 32'd0);
        @(negedge fclk);
    endtask

    initial begin
        int n;
        resetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'b010;
        hwrite = 1'b0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge fclk);
        chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("rst_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", {20'd0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        resetn = 1'b1;
        @(negedge fclk);

        // IDLE then BUSY while selected: no wait states, no APB activity
        hsel = 1'b1; haddr = 32'h4000_0A14; hsize = 3'b010;
        for (int i = 0; i < 4; i++) begin
            htrans = (i < 2) ? 2'b00 : 2'b01;
            @(negedge fclk);
            chk("idle_hreadyout", {31'd0, hreadyout}, 32'd1);
            chk("idle_hresp", {31'd0, hresp}, 32'd0);
            chk("idle_psel", {31'd0, psel}, 32'd0);
        end

        // Word write, pready tied high
        issue(32'h4000_0A14, 1, 3'b010, 32'hDEAD_BEEF, 1, 2, 0, 0, 32'h0, 0, 4, 32'h0);
        drain();

        // Word read, 3 stalled ACCESS cycles
        issue(32'h4000_0100, 0, 3'b010, 32'h0, 1, 1, 3, 0, 32'h1234_5678, 0, 6, 32'h1234_5678);
        drain();

        // Read with slave error; hrdata keeps previous value; read accepted in ERR2
        issue(32'h4000_0104, 0, 3'b010, 32'h0, 1, 1, 0, 1, 32'hFFFF_0000, 1, 4, 32'h1234_5678);
        issue(32'h4000_0108, 0, 3'b010, 32'h0, 1, 1, 0, 0, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D);
        drain();

        // Byte write rejected, then back-to-back read, write, read
        issue(32'h4000_0200, 1, 3'b000, 32'h0000_00AB, 0, 0, 0, 0, 32'h0, 1, 2, 32'h0);
        issue(32'h4000_010C, 0, 3'b010, 32'h0, 1, 1, 0, 0, 32'h0BAD_C0DE, 0, 3, 32'h0BAD_C0DE);
        issue(32'h4000_0110, 1, 3'b010, 32'h55AA_33CC, 1, 2, 1, 0, 32'h0, 0, 5, 32'h0);
        issue(32'h4000_0114, 0, 3'b010, 32'h0, 1, 1, 0, 0, 32'h8765_4321, 0, 3, 32'h8765_4321);
        drain();

        // Reset during ACCESS
        issue(32'h4000_0118, 0, 3'b010, 32'h0, 1, 1, 50, 0, 32'h1111_1111, 0, 53, 32'h1111_1111);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge fclk);
            n++;
        end
        chk("mid_reset_in_access", {31'd0, psel && penable}, 32'd1);
        #2;
        resetn = 1'b0;
        sb_q.delete();
        apb_q.delete();
        #1;
        chk("async_rst_psel", {31'd0, psel}, 32'd0);
        chk("async_rst_penable", {31'd0, penable}, 32'd0);
        chk("async_rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("async_rst_hrdata", hrdata, 32'd0);
        @(negedge fclk);
        resetn = 1'b1;
        @(negedge fclk);
        issue(32'h4000_011C, 0, 3'b010, 32'h0, 1, 1, 0, 0, 32'h600D_F00D, 0, 3, 32'h600D_F00D);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
